// File: rtl/coproc_pkg.sv
// Shared types and constants for the image coprocessor sequencer.
// Used by coproc_sequencer and seq_watchdog.
package coproc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_START   = 3'd1,
    ST_PROCESS = 3'd2,
    ST_SHOW    = 3'd3,
    ST_ERR     = 3'd4
  } seq_state_t;

  // Algorithm codes shared with zoom_controller, image_processing, display.
  localparam logic [1:0] ALG_NEAREST   = 2'd0;
  localparam logic [1:0] ALG_REPLICATE = 2'd1;
  localparam logic [1:0] ALG_DECIMATE  = 2'd2;
  localparam logic [1:0] ALG_AVERAGE   = 2'd3;

  localparam int DEFAULT_TIMEOUT_CYCLES = 2000000;

  function automatic int wd_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/seq_watchdog.sv
// Pass watchdog: counts enabled cycles, flags expiry at TIMEOUT_CYCLES-1.
// Instantiated by coproc_sequencer only when SEQ_TIMEOUT_EN is defined.
module seq_watchdog
  import coproc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CW = wd_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  assign expired = enable && (count == LIMIT);

endmodule

// File: rtl/coproc_sequencer.sv
// Image coprocessor pass sequencer: RUN -> one image_processing pass.
// Watchdog and ERR state are present only with SEQ_TIMEOUT_EN defined.
module coproc_sequencer
  import coproc_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int WCOUNT_W = 17
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                RUN,
  input  logic [1:0]          ALGORITHM,
  input  logic                PROC_DONE,
  input  logic                PROC_WVALID,
  output logic                PROC_START,
  output logic [1:0]          ALG_LATCHED,
  output logic                RAM_WREN,
  output logic                ZOOM_REQ,
  output logic                DISP_SEL,
  output logic                BUSY,
  output logic                ERROR,
  output logic [2:0]          STATE_CODE,
  output logic [WCOUNT_W-1:0] WR_COUNT
);

  seq_state_t state;
  seq_state_t state_nxt;
  logic       wd_expired;

`ifdef SEQ_TIMEOUT_EN
  seq_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (CLK),
    .rst_n  (RESET),
    .clear  (state == ST_START),
    .enable (state == ST_PROCESS),
    .expired(wd_expired)
  );
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYCLES > 0);
  assign wd_expired = 1'b0;
  assign ERROR = 1'b0;
`endif

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (RUN) state_nxt = ST_START;
      end
      ST_START: state_nxt = ST_PROCESS;
      ST_PROCESS: begin
        if (PROC_DONE)       state_nxt = ST_SHOW;
        else if (wd_expired) state_nxt = ST_ERR;
      end
      ST_SHOW: begin
        if (RUN)
          state_nxt = ST_START;
        else if (ALGORITHM != ALG_LATCHED)
          state_nxt = ST_IDLE;
      end
      ST_ERR: begin
        if (RUN) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Write strobe stays combinational to line up with W_ADDR/PIXEL_OUT.
  assign RAM_WREN = (state == ST_PROCESS) && PROC_WVALID;

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state       <= ST_IDLE;
      PROC_START  <= 1'b0;
      ALG_LATCHED <= 2'd0;
      ZOOM_REQ    <= 1'b0;
      DISP_SEL    <= 1'b0;
      BUSY        <= 1'b0;
      STATE_CODE  <= 3'd0;
      WR_COUNT    <= '0;
`ifdef SEQ_TIMEOUT_EN
      ERROR       <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      PROC_START <= (state_nxt == ST_START);
      BUSY       <= (state_nxt == ST_START) ||
                    (state_nxt == ST_PROCESS);
      ZOOM_REQ   <= (state_nxt == ST_START) ||
                    (state_nxt == ST_PROCESS);
      DISP_SEL   <= (state_nxt == ST_SHOW);
      STATE_CODE <= state_nxt;
`ifdef SEQ_TIMEOUT_EN
      ERROR      <= (state_nxt == ST_ERR);
`endif
      // START is only ever entered on an accepted RUN.
      if (state_nxt == ST_START) begin
        ALG_LATCHED <= ALGORITHM;
        WR_COUNT    <= '0;
      end else if (RAM_WREN &&
                   WR_COUNT != {WCOUNT_W{1'b1}}) begin
        WR_COUNT <= WR_COUNT + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_coproc_sequencer.sv
// Directed bench for coproc_sequencer: main pass, gating, watchdog, reset.
// The small-counter/short-timeout instance exercises saturation and expiry.
module tb_coproc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        run;
  logic [1:0]  algorithm;
  logic        proc_done;
  logic        proc_wvalid;

  logic        proc_start;
  logic [1:0]  alg_latched;
  logic        ram_wren;
  logic        zoom_req;
  logic        disp_sel;
  logic        busy;
  logic        error;
  logic [2:0]  state_code;
  logic [16:0] wr_count;

  logic        s_proc_start;
  logic [1:0]  s_alg_latched;
  logic        s_ram_wren;
  logic        s_zoom_req;
  logic        s_disp_sel;
  logic        s_busy;
  logic        s_error;
  logic [2:0]  s_state_code;
  logic [2:0]  s_wr_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  coproc_sequencer #(
    .TIMEOUT_CYCLES(2000000),
    .WCOUNT_W(17)
  ) dut (
    .CLK(clk), .RESET(rst_n), .RUN(run),
    .ALGORITHM(algorithm), .PROC_DONE(proc_done),
    .PROC_WVALID(proc_wvalid),
    .PROC_START(proc_start), .ALG_LATCHED(alg_latched),
    .RAM_WREN(ram_wren), .ZOOM_REQ(zoom_req),
    .DISP_SEL(disp_sel), .BUSY(busy), .ERROR(error),
    .STATE_CODE(state_code), .WR_COUNT(wr_count)
  );

  coproc_sequencer #(
    .TIMEOUT_CYCLES(100),
    .WCOUNT_W(3)
  ) dut_s (
    .CLK(clk), .RESET(rst_n), .RUN(run),
    .ALGORITHM(algorithm), .PROC_DONE(proc_done),
    .PROC_WVALID(proc_wvalid),
    .PROC_START(s_proc_start), .ALG_LATCHED(s_alg_latched),
    .RAM_WREN(s_ram_wren), .ZOOM_REQ(s_zoom_req),
    .DISP_SEL(s_disp_sel), .BUSY(s_busy), .ERROR(s_error),
    .STATE_CODE(s_state_code), .WR_COUNT(s_wr_count)
  );

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_run();
    run = 1'b1;
    tick();
    run = 1'b0;
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_state"}, 32'(state_code), 0);
    chk({tag, "_start"}, 32'(proc_start), 0);
    chk({tag, "_alg"},   32'(alg_latched), 0);
    chk({tag, "_wren"},  32'(ram_wren), 0);
    chk({tag, "_zoom"},  32'(zoom_req), 0);
    chk({tag, "_disp"},  32'(disp_sel), 0);
    chk({tag, "_busy"},  32'(busy), 0);
    chk({tag, "_err"},   32'(error), 0);
    chk({tag, "_wcnt"},  32'(wr_count), 0);
  endtask

  initial begin
    #5ms;
    $display("FAIL sim_timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    run = 1'b0;
    algorithm = 2'd0;
    proc_done = 1'b0;
    proc_wvalid = 1'b0;
    #1;
    chk_reset_vals("rst");
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("idle_state", 32'(state_code), 0);

    // Basic pass with ALGORITHM = 2
    algorithm = 2'd2;
    pulse_run();
    chk("start_pulse", 32'(proc_start), 1);
    chk("start_state", 32'(state_code), 1);
    chk("start_alg", 32'(alg_latched), 2);
    chk("start_busy", 32'(busy), 1);
    chk("start_zoom", 32'(zoom_req), 1);
    tick();
    chk("proc_state", 32'(state_code), 2);
    chk("proc_start_low", 32'(proc_start), 0);
    chk("proc_busy", 32'(busy), 1);

    proc_wvalid = 1'b1;
    #1;
    chk("proc_wren_hi", 32'(ram_wren), 1);
    proc_wvalid = 1'b0;
    #1;
    chk("proc_wren_lo", 32'(ram_wren), 0);

    // ALGORITHM change and RUN during PROCESS
    algorithm = 2'd1;
    pulse_run();
    chk("proc_run_ign", 32'(state_code), 2);
    chk("proc_alg_hold", 32'(alg_latched), 2);
    chk("proc_no_restart", 32'(proc_start), 0);

    proc_wvalid = 1'b1;
    repeat (10) tick();
    chk("wcnt_10", 32'(wr_count), 10);
    chk("wcnt_sat", 32'(s_wr_count), 7);
    repeat (76800 - 11) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    proc_wvalid = 1'b0;
    chk("done_wcnt", 32'(wr_count), 76800);
    chk("done_disp", 32'(disp_sel), 1);
    chk("done_state", 32'(state_code), 3);
    chk("done_busy", 32'(busy), 0);
    chk("done_zoom", 32'(zoom_req), 0);
    chk("done_alg", 32'(alg_latched), 2);

    proc_wvalid = 1'b1;
    #1;
    chk("show_wren", 32'(ram_wren), 0);
    proc_wvalid = 1'b0;
    tick();
    chk("stale_idle", 32'(state_code), 0);
    chk("stale_disp", 32'(disp_sel), 0);

    proc_wvalid = 1'b1;
    #1;
    chk("idle_wren", 32'(ram_wren), 0);
    proc_done = 1'b1;
    tick();
    proc_wvalid = 1'b0;
    proc_done = 1'b0;
    chk("idle_ign_state", 32'(state_code), 0);
    chk("idle_ign_wcnt", 32'(wr_count), 76800);

    // Short pass, then RUN with a new algorithm from SHOW
    algorithm = 2'd3;
    pulse_run();
    chk("p2_alg", 32'(alg_latched), 3);
    chk("p2_wcnt_clr", 32'(wr_count), 0);
    tick();
    proc_wvalid = 1'b1;
    tick();
    tick();
    proc_wvalid = 1'b0;
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("p2_state", 32'(state_code), 3);
    chk("p2_wcnt", 32'(wr_count), 2);
    algorithm = 2'd1;
    pulse_run();
    chk("show_run_state", 32'(state_code), 1);
    chk("show_run_alg", 32'(alg_latched), 1);
    chk("show_run_wcnt", 32'(wr_count), 0);
    chk("show_run_start", 32'(proc_start), 1);
    tick();
    proc_wvalid = 1'b1;
    tick();
    proc_wvalid = 1'b0;
    chk("p3_wcnt", 32'(wr_count), 1);

    // Asynchronous reset during PROCESS
    rst_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    tick();
    rst_n = 1'b1;
    tick();

    // Watchdog on the TIMEOUT_CYCLES = 100 instance
    algorithm = 2'd2;
    pulse_run();
    tick();
    repeat (99) tick();
    chk("wd_pre_state", 32'(s_state_code), 2);
`ifdef SEQ_TIMEOUT_EN
    tick();
    chk("wd_err_state", 32'(s_state_code), 4);
    chk("wd_err_flag", 32'(s_error), 1);
    chk("wd_err_disp", 32'(s_disp_sel), 0);
    chk("wd_err_busy", 32'(s_busy), 0);
    pulse_run();
    chk("wd_clr_state", 32'(s_state_code), 0);
    chk("wd_clr_flag", 32'(s_error), 0);
    pulse_run();
    tick();
    repeat (99) tick();
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("wd_done_wins", 32'(s_state_code), 3);
    chk("wd_done_err", 32'(s_error), 0);
`else
    repeat (50) tick();
    chk("nowd_state", 32'(s_state_code), 2);
    chk("nowd_err", 32'(s_error), 0);
    proc_done = 1'b1;
    tick();
    proc_done = 1'b0;
    chk("nowd_done", 32'(s_state_code), 3);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
